// File: rtl/fmap_uart_sender_if.sv
// Transmit-side bundle between the top-level FSM and the feature-map UART sender.
interface fmap_uart_sender_if #(
  parameter int unsigned DataW = 144
) ();
  logic             transmit;
  logic [DataW-1:0] data;
  logic             TxD;
  logic             busy;
  logic             done_transmitting;

  // Controller side: issues the request and map, observes the line and status.
  modport master (
    output transmit,
    output data,
    input  TxD,
    input  busy,
    input  done_transmitting
  );

  // Sender side.
  modport slave (
    input  transmit,
    input  data,
    output TxD,
    output busy,
    output done_transmitting
  );
endinterface

// File: rtl/fmap_uart_sender.sv
// Snapshots a ROWS x COLS feature map and sends it as an 8N1 UART frame:
// header byte, one zero-extended byte per pixel (row-major), then a mod-256 pixel checksum.
module fmap_uart_sender #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ROWS         = 6,
  parameter int unsigned COLS         = 6,
  parameter int unsigned PIX_W        = 4,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic             clk,
  input  logic             reset_n,
  fmap_uart_sender_if.slave bus
);
  localparam int unsigned NPix  = ROWS * COLS;
  localparam int unsigned DataW = NPix * PIX_W;
  localparam int unsigned IdxW  = $clog2(NPix + 2);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e           state;
  logic [BaudW-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [IdxW-1:0]  byte_idx;
  logic [7:0]       checksum;
  logic [DataW-1:0] snap_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             armed;

  logic             baud_last;
  logic [7:0]       cur_byte;
  logic [7:0]       next_pix;

  // Zero-extended pixel k of a snapshot; out-of-range k yields 0.
  function automatic logic [7:0] pix_at(input logic [DataW-1:0] map, input int unsigned k);
    logic [DataW-1:0] sh;
    sh = map >> (k * PIX_W);
    return 8'(sh[PIX_W-1:0]);
  endfunction

  // Byte currently on the wire, and the pixel that the next START will add to the checksum.
  always_comb begin
    baud_last = (baud_cnt == BaudW'(CLKS_PER_BIT - 1));
    next_pix  = pix_at(snap_reg, 32'(byte_idx));
    cur_byte  = HDR_BYTE;
    if (byte_idx == '0) begin
      cur_byte = HDR_BYTE;
    end else if (32'(byte_idx) <= NPix) begin
      cur_byte = pix_at(snap_reg, 32'(byte_idx) - 32'd1);
    end else begin
      cur_byte = checksum;
    end
  end

  // Frame FSM; TxD, busy and done are loaded with the value of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= StIdle;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      checksum <= '0;
      snap_reg <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      armed    <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          tx_reg   <= 1'b1;
          done_reg <= 1'b0;
          if (!bus.transmit) begin
            armed <= 1'b1;
          end else if (armed) begin
            snap_reg <= bus.data;
            byte_idx <= '0;
            checksum <= '0;
            baud_cnt <= '0;
            busy_reg <= 1'b1;
            armed    <= 1'b0;
            tx_reg   <= 1'b0;
            state    <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_reg   <= cur_byte[0];
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_reg <= 1'b1;
              state  <= StStop;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_reg  <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (32'(byte_idx) < NPix + 1) begin
              byte_idx <= byte_idx + IdxW'(1);
              // Next byte is a pixel: fold it in as it enters START.
              if (32'(byte_idx) < NPix) begin
                checksum <= checksum + next_pix;
              end
              tx_reg <= 1'b0;
              state  <= StStart;
            end else begin
              done_reg <= 1'b1;
              state    <= StDone;
            end
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        StDone: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.TxD               = tx_reg;
  assign bus.busy              = busy_reg;
  assign bus.done_transmitting = done_reg;
endmodule

// File: tb/tb_fmap_uart_sender.sv
// Bench for fmap_uart_sender: UART line decoder plus a frame model built from the map snapshot.
module tb_fmap_uart_sender;
  localparam int unsigned CPB   = 4;
  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 6;
  localparam int unsigned PIX_W = 4;
  localparam int unsigned NPIX  = ROWS * COLS;
  localparam int unsigned DW    = NPIX * PIX_W;
  localparam int          FRAME_CYC = (NPIX + 2) * 10 * CPB;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  fmap_uart_sender_if #(.DataW(DW)) bus ();

  fmap_uart_sender #(
    .CLKS_PER_BIT(CPB),
    .ROWS        (ROWS),
    .COLS        (COLS),
    .PIX_W       (PIX_W),
    .HDR_BYTE    (8'hA5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         frame_err = 0;
  bit         mon_busy  = 1'b0;

  typedef struct {
    string      name;
    logic [DW-1:0] data;
    int         sum;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected byte stream: header, each pixel as a byte, then the 8-bit sum of the pixels.
  function automatic void model(input logic [DW-1:0] d);
    int s;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    s = 0;
    for (int k = 0; k < int'(NPIX); k++) begin
      int p;
      p = int'(d[k*PIX_W +: PIX_W]);
      exp_q.push_back(8'(p));
      s += p;
    end
    exp_q.push_back(8'(s % 256));
  endfunction

  // Reference UART receiver: sample each bit at its centre, stamp the start-bit cycle.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && bus.TxD === 1'b0) begin
        int t0;
        mon_busy = 1'b1;
        t0 = cyc;
        b = '0;
        repeat (CPB / 2) @(negedge clk);
        if (bus.TxD !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.TxD;
        end
        repeat (CPB) @(negedge clk);
        if (bus.TxD !== 1'b1) frame_err++;
        rx_q.push_back(b);
        rx_t.push_back(t0);
        mon_busy = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] fill_all(input int v);
    logic [DW-1:0] d;
    for (int k = 0; k < int'(NPIX); k++) d[k*PIX_W +: PIX_W] = PIX_W'(v);
    return d;
  endfunction

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    frame_err = 0;
  endtask

  // Wait for done from the current negedge (first start-bit cycle); optionally rewrite the map
  // and poke transmit mid-frame at iteration rw_at.
  task automatic wait_done(output int dcyc, output int busy_low, input int rw_at,
                           input logic [DW-1:0] rw_data);
    dcyc     = -1;
    busy_low = 0;
    for (int i = 0; i < FRAME_CYC + 200; i++) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.done_transmitting === 1'b1) begin
        dcyc = cyc;
        break;
      end
      if (i == rw_at) begin
        bus.data     = rw_data;
        bus.transmit = 1'b1;
      end
      if (i == rw_at + 1) bus.transmit = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic verify_rx(input string name, input int exp_sum);
    int mism;
    check({name, "_nbytes"}, rx_q.size(), NPIX + 2);
    mism = 0;
    for (int i = 0; i < rx_q.size() && i < int'(NPIX) + 2; i++)
      if (rx_q[i] !== exp_q[i]) mism++;
    check({name, "_bytes"}, mism, 0);
    check({name, "_framing"}, frame_err, 0);
    if (exp_sum >= 0)
      check({name, "_sum"}, (rx_q.size() >= NPIX + 2) ? int'(rx_q[NPIX+1]) : -1, exp_sum);
  endtask

  task automatic finish_frame(input string name, input int dcyc, input int busy_low,
                              input int exp_sum);
    int lat;
    lat = (dcyc < 0 || rx_t.size() == 0) ? -1 : dcyc - rx_t[0];
    check({name, "_done_latency"}, lat, FRAME_CYC);
    check({name, "_busy_gap"}, busy_low, 0);
    @(negedge clk);
    check({name, "_busy_after"}, int'(bus.busy), 0);
    check({name, "_done_after"}, int'(bus.done_transmitting), 0);
    repeat (100) @(negedge clk);
    verify_rx(name, exp_sum);
  endtask

  task automatic run_frame(input string name, input logic [DW-1:0] d, input int exp_sum,
                           input int rw_at, input logic [DW-1:0] rw_data);
    int dcyc, busy_low;
    model(d);
    clear_rx();
    @(negedge clk);
    bus.data     = d;
    bus.transmit = 1'b1;
    @(negedge clk);
    bus.transmit = 1'b0;
    wait_done(dcyc, busy_low, rw_at, rw_data);
    finish_frame(name, dcyc, busy_low, exp_sum);
  endtask

  initial begin
    logic [DW-1:0] kmod;
    int dcyc, busy_low, cnt;

    for (int k = 0; k < int'(NPIX); k++) kmod[k*PIX_W +: PIX_W] = PIX_W'(k % 10);
    vecs[0] = '{name: "zeros", data: fill_all(0), sum: 8'h00};
    vecs[1] = '{name: "kmod10", data: kmod, sum: 8'h96};
    vecs[2] = '{name: "nines", data: fill_all(9), sum: 8'h44};

    reset_n      = 1'b0;
    bus.transmit = 1'b0;
    bus.data     = '0;
    repeat (3) @(negedge clk);
    check("reset_txd", int'(bus.TxD), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done_transmitting), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) run_frame(vecs[i].name, vecs[i].data, vecs[i].sum, -1, '0);

    for (int r = 0; r < 3; r++) begin
      logic [DW-1:0] d;
      for (int k = 0; k < int'(NPIX); k++) d[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 15));
      run_frame($sformatf("rand%0d", r), d, -1, -1, '0);
    end

    // Map rewritten and transmit poked during byte 5: snapshot must win.
    run_frame("snapshot", kmod, 8'h96, 5 * 10 * CPB + 10, fill_all(9));

    // Request held high through done: one frame only, then re-arm after a one-cycle drop.
    model(kmod);
    clear_rx();
    @(negedge clk);
    bus.data     = kmod;
    bus.transmit = 1'b1;
    @(negedge clk);
    wait_done(dcyc, busy_low, -1, '0);
    finish_frame("hold", dcyc, busy_low, 8'h96);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy !== 1'b0 || bus.TxD !== 1'b1) cnt++;
      @(negedge clk);
    end
    check("hold_no_retrigger", cnt, 0);
    check("hold_no_extra_bytes", rx_q.size(), NPIX + 2);
    clear_rx();
    bus.transmit = 1'b0;
    @(negedge clk);
    bus.transmit = 1'b1;
    @(negedge clk);
    check("rearm_txd", int'(bus.TxD), 0);
    check("rearm_busy", int'(bus.busy), 1);
    wait_done(dcyc, busy_low, -1, '0);
    bus.transmit = 1'b0;
    finish_frame("rearm", dcyc, busy_low, 8'h96);

    // Reset during bit 3 of byte 10 aborts silently.
    clear_rx();
    @(negedge clk);
    bus.data     = kmod;
    bus.transmit = 1'b1;
    @(negedge clk);
    bus.transmit = 1'b0;
    repeat (10 * 10 * CPB + CPB + 3 * CPB + 1) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_txd", int'(bus.TxD), 1);
    check("abort_busy", int'(bus.busy), 0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (bus.done_transmitting === 1'b1) cnt++;
      @(negedge clk);
    end
    check("abort_no_done", cnt, 0);
    for (int i = 0; i < 100 && mon_busy; i++) @(negedge clk);
    begin
      logic [DW-1:0] d;
      for (int k = 0; k < int'(NPIX); k++) d[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 9));
      run_frame("after_abort", d, -1, -1, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
